frame_config_sequencer: RTL and testbench
=========================================

// Module: frame_config_sequencer
// PURPOSE
//  Writes configuration frames into the fabric, one frame per handshake.
//  Takes (column, frame index, data) requests from the bitstream loader.
//  Drives the shared FrameData bus, the column FrameSelect/FrameStrobe pair and
//  the one-hot FrameStrobe_I vector consumed by the per-column frame-select gates.
//  Enforces setup/strobe/hold ordering, so data and select are stable around each strobe.
// PARAMETERS
//  MaxFramesPerCol   20  width of the one-hot FrameStrobe_I vector
//  FrameSelectWidth   5  width of the column select
//  FrameIndexWidth    5  width of the frame index in a request
//  FrameBitsPerRow   32  FrameData width
//  NumColumns         8  valid columns are 0..NumColumns-1
//  StrobeCycles       2  cycles FrameStrobe is held high (>=1)
// PORTS
//  CLK             in   1     clock; all state changes on the rising edge
//  reset           in   1     asynchronous, active-high reset
//  req_valid       in   1     request present
//  req_ready       out  1     request accepted when req_valid & req_ready
//  req_col         in   FrameSelectWidth   target column
//  req_frame       in   FrameIndexWidth    frame index within the column
//  req_data        in   FrameBitsPerRow    frame data word
//  FrameData       out  FrameBitsPerRow    registered data to the fabric
//  FrameSelect     out  FrameSelectWidth   registered column select
//  FrameStrobe     out  1                  registered column strobe
//  FrameStrobe_I   out  MaxFramesPerCol    registered one-hot frame strobe
//  busy            out  1     high in any state other than IDLE
//  err             out  1     one-cycle pulse on an out-of-range request
//  frames_written  out  16    count of completed frames; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0 except req_ready=1.
//    FrameStrobe and FrameStrobe_I drop to 0 immediately, even mid-frame; the
//    partial frame is abandoned and not counted.
//  States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
//  IDLE: req_ready=1. On valid&ready the request is latched. It is range-checked:
//    req_col>=NumColumns or req_frame>=MaxFramesPerCol is out of range.
//    In range: go to SETUP. Out of range: stay in IDLE; err=1 in the next cycle;
//    no fabric outputs change; the request is consumed (not retried).
//  SETUP (1 cycle): FrameData=data, FrameSelect=col,
//    FrameStrobe_I=1<<frame; FrameStrobe=0; req_ready=0.
//  STROBE (StrobeCycles cycles): FrameStrobe=1. Data, select and one-hot are unchanged.
//    A down-counter of width clog2(StrobeCycles+1) times this state.
//  HOLD (1 cycle): FrameStrobe=0, FrameStrobe_I=0. FrameData and FrameSelect are held.
//    frames_written increments on HOLD entry.
//  After HOLD: return to IDLE. FrameData and FrameSelect keep their last value until
//    the next SETUP.
//  Cycle timing: handshake at edge 0 -> SETUP visible after edge 1 -> strobe high after
//    edges 2..1+StrobeCycles -> HOLD -> req_ready=1 again StrobeCycles+3 cycles after
//    acceptance. No back-to-back overlap.
//  req_* inputs are ignored while req_ready=0. Inputs are sampled only at the handshake.
//  FrameStrobe_I is one-hot or all zeros at all times, never multi-hot.
//  frames_written stays at 16'hFFFF once reached; no wrap.
//  err and a valid request never coincide with a strobe, because err is only raised from IDLE.
// TESTING
//  Reset then one request col=3 frame=7 data=32'hDEADBEEF ->
//    SETUP: FrameSelect=3, FrameStrobe_I=20'h00080; strobe high 2 cycles; frames_written=1.
//  req_valid held high with 4 requests ->
//    each is accepted exactly every 5 cycles (StrobeCycles=2); frames_written=4.
//  Request col=8 or frame=20 -> err pulses 1 cycle; FrameStrobe stays 0;
//    frames_written unchanged; req_ready stays 1.
//  Assert reset during STROBE -> FrameStrobe and FrameStrobe_I are 0 at once; after release
//    state=IDLE, req_ready=1, count not incremented.
//  Preload frames_written=16'hFFFE, run 3 frames -> value is 16'hFFFF and holds.
//  Change req_data and req_col during SETUP/STROBE -> FrameData and FrameSelect are unchanged.

Source files
------------

// File: rtl/frame_config_sequencer.sv
// Writes one configuration frame per request: SETUP, StrobeCycles of FrameStrobe, HOLD.
// Latency: request accepted every StrobeCycles+3 cycles; req_ready low while a frame is in flight.
module frame_config_sequencer #(
    parameter int          MaxFramesPerCol  = 20,
    parameter int          FrameSelectWidth = 5,
    parameter int          FrameIndexWidth  = 5,
    parameter int          FrameBitsPerRow  = 32,
    parameter int          NumColumns       = 8,
    parameter int          StrobeCycles     = 2,
    parameter logic [15:0] CountResetValue  = 16'h0000
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [FrameSelectWidth-1:0] req_col,
    input  logic [FrameIndexWidth-1:0]  req_frame,
    input  logic [FrameBitsPerRow-1:0]  req_data,
    output logic [FrameBitsPerRow-1:0]  FrameData,
    output logic [FrameSelectWidth-1:0] FrameSelect,
    output logic                        FrameStrobe,
    output logic [MaxFramesPerCol-1:0]  FrameStrobe_I,
    output logic                        busy,
    output logic                        err,
    output logic [15:0]                 frames_written
);

    localparam int CntW = $clog2(StrobeCycles + 1);
    localparam logic [FrameSelectWidth:0] ColLimit   = (FrameSelectWidth + 1)'(NumColumns);
    localparam logic [FrameIndexWidth:0]  FrameLimit = (FrameIndexWidth + 1)'(MaxFramesPerCol);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    typedef struct packed {
        logic [FrameSelectWidth-1:0] col;
        logic [FrameIndexWidth-1:0]  frame;
        logic [FrameBitsPerRow-1:0]  data;
    } req_t;

    state_t          state;
    req_t            req_q;
    logic [CntW-1:0] cnt;
    logic            accept;
    logic            out_of_range;

    assign accept       = req_valid & req_ready;
    assign out_of_range = ({1'b0, req_col} >= ColLimit) || ({1'b0, req_frame} >= FrameLimit);

    // Fabric outputs are registered on leaving each state, so every phase
    // becomes visible one cycle after its state is entered.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            req_q          <= '0;
            cnt            <= '0;
            req_ready      <= 1'b1;
            FrameData      <= '0;
            FrameSelect    <= '0;
            FrameStrobe    <= 1'b0;
            FrameStrobe_I  <= '0;
            busy           <= 1'b0;
            err            <= 1'b0;
            frames_written <= CountResetValue;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (out_of_range) begin
                            err <= 1'b1;
                        end else begin
                            req_q     <= '{col: req_col, frame: req_frame, data: req_data};
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                            state     <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    FrameData     <= req_q.data;
                    FrameSelect   <= req_q.col;
                    FrameStrobe_I <= {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << req_q.frame;
                    cnt           <= CntW'(StrobeCycles);
                    state         <= STROBE;
                end
                STROBE: begin
                    FrameStrobe <= 1'b1;
                    cnt         <= cnt - CntW'(1);
                    if (cnt == CntW'(1)) state <= HOLD;
                end
                HOLD: begin
                    // Data and select stay put for the hold cycle and beyond.
                    FrameStrobe   <= 1'b0;
                    FrameStrobe_I <= '0;
                    if (frames_written != 16'hFFFF) frames_written <= frames_written + 16'd1;
                    req_ready     <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Bench for frame_config_sequencer: directed requests, expected frames/errors queued
// by the driver and popped by a negedge monitor when the DUT strobes or flags err.
module tb_frame_config_sequencer;

    localparam int S = 2;

    typedef struct packed {
        logic [4:0]  col;
        logic [19:0] oh;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [4:0]  req_col = '0;
    logic [4:0]  req_frame = '0;
    logic [31:0] req_data = '0;

    logic        req_ready, FrameStrobe, busy, err;
    logic [31:0] FrameData;
    logic [4:0]  FrameSelect;
    logic [19:0] FrameStrobe_I;
    logic [15:0] frames_written;

    logic        sat_ready, sat_strobe, sat_busy, sat_err;
    logic [31:0] sat_data;
    logic [4:0]  sat_sel;
    logic [19:0] sat_i;
    logic [15:0] sat_count;

    frame_config_sequencer dut (
        .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_col(req_col), .req_frame(req_frame), .req_data(req_data),
        .FrameData(FrameData), .FrameSelect(FrameSelect), .FrameStrobe(FrameStrobe),
        .FrameStrobe_I(FrameStrobe_I), .busy(busy), .err(err), .frames_written(frames_written)
    );

    // Second instance starts its count near the top to exercise saturation.
    frame_config_sequencer #(.CountResetValue(16'hFFFE)) dut_sat (
        .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(sat_ready),
        .req_col(req_col), .req_frame(req_frame), .req_data(req_data),
        .FrameData(sat_data), .FrameSelect(sat_sel), .FrameStrobe(sat_strobe),
        .FrameStrobe_I(sat_i), .busy(sat_busy), .err(sat_err), .frames_written(sat_count)
    );

    always #5 CLK = ~CLK;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   last_rise = 0;
    exp_t frm_q[$];
    int   err_q[$];

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations when the DUT strobes a frame or raises err.
    initial begin : monitor
        logic        prev_strb;
        int          hi_len;
        logic [31:0] cap_data, prev_data;
        logic [4:0]  cap_sel, prev_sel;
        logic [19:0] cap_i;
        exp_t        e;
        prev_strb = 1'b0; hi_len = 0;
        cap_data = '0; prev_data = '0; cap_sel = '0; prev_sel = '0; cap_i = '0;
        forever begin
            @(negedge CLK);
            if (reset) begin
                prev_strb = 1'b0;
                hi_len    = 0;
            end else begin
                if (err) begin
                    if (err_q.size() == 0) chk("err_unexpected", 32'(err), 0);
                    else begin
                        void'(err_q.pop_front());
                        chk("err_no_strobe", 32'(FrameStrobe), 0);
                    end
                end
                if (FrameStrobe && !prev_strb) begin
                    last_rise = cyc;
                    hi_len    = 1;
                    if (frm_q.size() == 0) chk("frame_unexpected", 32'(FrameStrobe), 0);
                    else begin
                        e = frm_q.pop_front();
                        chk("frame_sel", 32'(FrameSelect), 32'(e.col));
                        chk("frame_onehot", 32'(FrameStrobe_I), 32'(e.oh));
                        chk("frame_data", FrameData, e.data);
                    end
                    chk("setup_data_before_strobe", prev_data, FrameData);
                    chk("setup_sel_before_strobe", 32'(prev_sel), 32'(FrameSelect));
                    cap_data = FrameData; cap_sel = FrameSelect; cap_i = FrameStrobe_I;
                end else if (FrameStrobe) begin
                    hi_len++;
                    chk("strobe_data_stable", FrameData, cap_data);
                    chk("strobe_sel_i_stable", 32'({FrameSelect, FrameStrobe_I}), 32'({cap_sel, cap_i}));
                end else if (prev_strb) begin
                    chk("strobe_len", 32'(hi_len), S);
                    chk("hold_onehot_zero", 32'(FrameStrobe_I), 0);
                    chk("hold_data", FrameData, cap_data);
                    chk("hold_sel", 32'(FrameSelect), 32'(cap_sel));
                end
                prev_strb = FrameStrobe;
            end
            prev_data = FrameData;
            prev_sel  = FrameSelect;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [4:0] c, input logic [4:0] f, input logic [31:0] d,
                         input logic [19:0] exp_i, input logic exp_err, output int acc);
        int n;
        req_valid = 1'b1; req_col = c; req_frame = f; req_data = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        acc = cyc;
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 1);
        end else begin
            if (exp_err) err_q.push_back(1);
            else frm_q.push_back('{col: c, oh: exp_i, data: d});
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(req_ready && !busy && !FrameStrobe) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'(busy), 0);
    endtask

    logic [4:0]  t2_col [4] = '{5'd0, 5'd7, 5'd1, 5'd6};
    logic [4:0]  t2_frm [4] = '{5'd0, 5'd19, 5'd1, 5'd12};
    logic [31:0] t2_dat [4] = '{32'h00000001, 32'hA5A55A5A, 32'h12345678, 32'hFFFF0000};
    logic [19:0] t2_oh  [4] = '{20'h00001, 20'h80000, 20'h00002, 20'h01000};

    initial begin : stim
        int a;
        int acc[4];
        int n;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);

        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_strobe", 32'(FrameStrobe), 0);
        chk("rst_onehot", 32'(FrameStrobe_I), 0);
        chk("rst_data", FrameData, 0);
        chk("rst_sel", 32'(FrameSelect), 0);
        chk("rst_count", 32'(frames_written), 0);
        chk("rst_sat_count", 32'(sat_count), 32'hFFFE);

        // Single frame col=3 frame=7
        issue(5'd3, 5'd7, 32'hDEADBEEF, 20'h00080, 1'b0, a);
        req_valid = 1'b0;
        chk("t1_onehot_not_early", 32'(FrameStrobe_I), 0);
        @(negedge CLK);
        chk("t1_setup_sel", 32'(FrameSelect), 3);
        chk("t1_setup_onehot", 32'(FrameStrobe_I), 32'h00080);
        chk("t1_setup_data", FrameData, 32'hDEADBEEF);
        chk("t1_setup_strobe_low", 32'(FrameStrobe), 0);
        wait_idle();
        chk("t1_strobe_latency", 32'(last_rise - a), 3);
        chk("t1_count", 32'(frames_written), 1);
        chk("t1_sat_count", 32'(sat_count), 32'hFFFF);

        // Four back-to-back requests with req_valid held high
        for (int i = 0; i < 4; i++) begin
            issue(t2_col[i], t2_frm[i], t2_dat[i], t2_oh[i], 1'b0, a);
            acc[i] = a;
        end
        req_valid = 1'b0;
        wait_idle();
        for (int i = 1; i < 4; i++) chk("t2_accept_interval", 32'(acc[i] - acc[i-1]), S + 3);
        chk("t2_count", 32'(frames_written), 5);
        chk("t2_sat_hold", 32'(sat_count), 32'hFFFF);

        // Out-of-range requests
        issue(5'd8, 5'd0, 32'h11111111, 20'h0, 1'b1, a);
        chk("t3_ready_after_err", 32'(req_ready), 1);
        issue(5'd2, 5'd20, 32'h22222222, 20'h0, 1'b1, a);
        issue(5'd31, 5'd31, 32'h33333333, 20'h0, 1'b1, a);
        req_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("t3_strobe_low", 32'(FrameStrobe), 0);
        chk("t3_count", 32'(frames_written), 5);
        chk("t3_ready", 32'(req_ready), 1);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_sel_unchanged", 32'(FrameSelect), 6);

        // Inputs change while busy; they must be ignored
        issue(5'd5, 5'd3, 32'h0BADF00D, 20'h00008, 1'b0, a);
        n = 0;
        while (!req_ready && n < 20) begin
            req_col = 5'd4; req_frame = 5'd2; req_data = 32'hCAFE0000 + 32'(n);
            @(negedge CLK);
            n++;
        end
        req_valid = 1'b0;
        wait_idle();
        chk("t5_count", 32'(frames_written), 6);
        chk("t5_data_kept", FrameData, 32'h0BADF00D);
        chk("t5_sel_kept", 32'(FrameSelect), 5);

        // Reset in the middle of the strobe
        issue(5'd4, 5'd10, 32'h13579BDF, 20'h00400, 1'b0, a);
        req_valid = 1'b0;
        n = 0;
        while (!FrameStrobe && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("t4_strobe_reached", 32'(FrameStrobe), 1);
        #2 reset = 1'b1;
        #1;
        chk("t4_strobe_drop", 32'(FrameStrobe), 0);
        chk("t4_onehot_drop", 32'(FrameStrobe_I), 0);
        @(negedge CLK);
        reset = 1'b0;
        repeat (4) @(negedge CLK);
        chk("t4_ready", 32'(req_ready), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_count", 32'(frames_written), 0);
        chk("t4_strobe_low", 32'(FrameStrobe), 0);
        chk("t4_sat_count", 32'(sat_count), 32'hFFFE);

        issue(5'd2, 5'd19, 32'h00C0FFEE, 20'h80000, 1'b0, a);
        req_valid = 1'b0;
        wait_idle();
        chk("t6_count", 32'(frames_written), 1);
        chk("t6_sat_count", 32'(sat_count), 32'hFFFF);

        repeat (2) @(negedge CLK);
        chk("frames_all_seen", 32'(frm_q.size()), 0);
        chk("errs_all_seen", 32'(err_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
